// File: rtl/sign_divider_arbiter.sv
// Round-robin sharing of one SignDivider between NUM_REQ requesters.
// Optional divider watchdog: define DIV_TIMEOUT_EN.
module sign_divider_arbiter #(
  parameter int WIDTH          = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [NUM_REQ*WIDTH-1:0]   ReqDividend,
  input  logic [NUM_REQ*WIDTH-1:0]   ReqDivider,
  input  logic [NUM_REQ-1:0]         ReqSign,
  output logic [NUM_REQ-1:0]         Grant,
  output logic [NUM_REQ-1:0]         Done,
  output logic [WIDTH-1:0]           Quotient,
  output logic [WIDTH-1:0]           Remainder,
  output logic                       Error,
  output logic                       Busy,
  output logic [WIDTH-1:0]           DivDividend,
  output logic [WIDTH-1:0]           DivDivider,
  output logic                       DivSign,
  input  logic                       DivReady,
  input  logic [WIDTH-1:0]           DivQuotient,
  input  logic [WIDTH-1:0]           DivRemainder
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE
  } state_t;

  state_t state;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    pick;
  logic             pick_ok;
  int               rr_j;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             sgn;
  logic             tag_ok;
  logic [WIDTH-1:0] tag_dvd;
  logic [WIDTH-1:0] tag_dvs;
  logic             tag_sgn;
  logic [WIDTH-1:0] cq;
  logic [WIDTH-1:0] cr;
  logic             hit;
  logic [CW-1:0]    tcnt;
  logic             tmo;

  // Lowest offset from ptr wins, so scan from the far end down.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    rr_j    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_j = int'(ptr) + k;
      if (rr_j >= NUM_REQ)
        rr_j = rr_j - NUM_REQ;
      if (Req[IW'(rr_j)]) begin
        pick    = IW'(rr_j);
        pick_ok = 1'b1;
      end
    end
  end

  assign hit = tag_ok && (tag_dvd == dvd) &&
               (tag_dvs == dvs) && (tag_sgn == sgn);

`ifdef DIV_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (Reset || state == ISSUE)
      tcnt <= '0;
    else if ((state == WAIT_LOW || state == WAIT_HIGH) && !tmo)
      tcnt <= tcnt + 1'b1;
  end
`else
  assign tcnt = '0;
`endif

  assign tmo = (state == WAIT_LOW || state == WAIT_HIGH) &&
               (tcnt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      sgn         <= 1'b0;
      tag_ok      <= 1'b0;
      tag_dvd     <= '0;
      tag_dvs     <= '0;
      tag_sgn     <= 1'b0;
      cq          <= '0;
      cr          <= '0;
      Grant       <= '0;
      Done        <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      Error       <= 1'b0;
      Busy        <= 1'b0;
      DivDividend <= '0;
      DivDivider  <= '0;
      DivSign     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pick_ok) begin
          owner <= pick;
          Grant <= NUM_REQ'(1) << pick;
          dvd   <= ReqDividend[pick*WIDTH +: WIDTH];
          dvs   <= ReqDivider[pick*WIDTH +: WIDTH];
          sgn   <= ReqSign[pick];
          Error <= 1'b0;
          Busy  <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          if (dvs == '0) begin
            Quotient  <= '1;
            Remainder <= dvd;
            Error     <= 1'b1;
            Done      <= Grant;
            state     <= DONE;
          end else if (hit) begin
            Quotient  <= cq;
            Remainder <= cr;
            Done      <= Grant;
            state     <= DONE;
          end else if (DivReady) begin
            DivDividend <= dvd;
            DivDivider  <= dvs;
            DivSign     <= sgn;
            tag_dvd     <= dvd;
            tag_dvs     <= dvs;
            tag_sgn     <= sgn;
            tag_ok      <= 1'b0;
            state       <= WAIT_LOW;
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (tmo) begin
            Quotient  <= '0;
            Remainder <= '0;
            Error     <= 1'b1;
            tag_ok    <= 1'b0;
            Done      <= Grant;
            state     <= DONE;
          end else if (state == WAIT_LOW) begin
            if (!DivReady)
              state <= WAIT_HIGH;
          end else if (DivReady) begin
            Quotient  <= DivQuotient;
            Remainder <= DivRemainder;
            cq        <= DivQuotient;
            cr        <= DivRemainder;
            tag_ok    <= 1'b1;
            Done      <= Grant;
            state     <= DONE;
          end
        end
        DONE: begin
          Grant <= '0;
          Done  <= '0;
          Busy  <= 1'b0;
          ptr   <= (owner == IW'(NUM_REQ - 1)) ?
                   '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_divider_arbiter.sv
// Bench for sign_divider_arbiter with a behavioural SignDivider model.
// Timeout scenario runs only when DIV_TIMEOUT_EN is defined.
module tb_sign_divider_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] ReqDividend = '0;
  logic [N*W-1:0] ReqDivider = '0;
  logic [N-1:0]   ReqSign = '0;
  logic [N-1:0]   Grant;
  logic [N-1:0]   Done;
  logic [W-1:0]   Quotient;
  logic [W-1:0]   Remainder;
  logic           Error;
  logic           Busy;
  logic [W-1:0]   DivDividend;
  logic [W-1:0]   DivDivider;
  logic           DivSign;
  logic           DivReady = 1'b1;
  logic [W-1:0]   DivQuotient = '0;
  logic [W-1:0]   DivRemainder = '0;

  int checks = 0;
  int errors = 0;
  int falls  = 0;
  int mptr   = 0;
  int dcnt   = 0;
  logic stuck = 1'b0;
  logic [2*W:0] last = '0;

  sign_divider_arbiter #(
    .WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .ReqDividend(ReqDividend), .ReqDivider(ReqDivider),
    .ReqSign(ReqSign), .Grant(Grant), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder),
    .Error(Error), .Busy(Busy),
    .DivDividend(DivDividend), .DivDivider(DivDivider),
    .DivSign(DivSign), .DivReady(DivReady),
    .DivQuotient(DivQuotient), .DivRemainder(DivRemainder)
  );

  always #5 Clk = ~Clk;

  function automatic logic [2*W-1:0] ref_div(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    if (b == '0) return {{W{1'b1}}, a};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return {W'(sa / sb), W'(sa % sb)};
    end
    return {a / b, a % b};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Divider: restarts whenever its inputs change, Ready low for 2..5 cycles.
  always @(posedge Clk) begin
    if (stuck)
      DivReady <= 1'b1;
    else if ({DivDividend, DivDivider, DivSign} !== last) begin
      last     <= {DivDividend, DivDivider, DivSign};
      DivReady <= 1'b0;
      dcnt     <= $urandom_range(4, 1);
    end else if (!DivReady) begin
      if (dcnt == 0) begin
        {DivQuotient, DivRemainder} <=
          ref_div(last[2*W:W+1], last[W:1], last[0]);
        DivReady <= 1'b1;
      end else
        dcnt <= dcnt - 1;
    end
  end

  always @(negedge DivReady) falls++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s);
    ReqDividend[i*W +: W] = a;
    ReqDivider[i*W +: W]  = b;
    ReqSign[i]            = s;
    Req[i]                = 1'b1;
  endtask

  task automatic wait_done(input int own, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic e,
                           input string tag);
    int n;
    n = 0;
    while (Done === '0 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, " bound"}, 32'(n < 400), 32'd1);
    chk({tag, " done"}, 32'(Done), 32'(1 << own));
    chk({tag, " grant"}, 32'(Grant), 32'(1 << own));
    chk({tag, " q"}, 32'(Quotient), 32'(q));
    chk({tag, " r"}, 32'(Remainder), 32'(r));
    chk({tag, " err"}, 32'(Error), 32'(e));
    Req[own] = 1'b0;
    tick();
    chk({tag, " done clr"}, 32'(Done), 32'd0);
    chk({tag, " grant clr"}, 32'(Grant), 32'd0);
    chk({tag, " idle"}, 32'(Busy), 32'd0);
    mptr = (own + 1) % N;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req   = '0;
    tick();
    tick();
    Reset = 1'b0;
    mptr  = 0;
    tick();
  endtask

  initial begin
    int f0, n, own;
    logic [W-1:0] a, b;
    logic s;
    logic [2*W-1:0] ex;
    logic [W-1:0] bpool [5];
    bpool = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd200};

    tick();
    tick();
    chk("rst grant", 32'(Grant), 0);
    chk("rst done", 32'(Done), 0);
    chk("rst q", 32'(Quotient), 0);
    chk("rst r", 32'(Remainder), 0);
    chk("rst err", 32'(Error), 0);
    chk("rst busy", 32'(Busy), 0);
    chk("rst dvd", 32'(DivDividend), 0);
    chk("rst dvs", 32'(DivDivider), 0);
    chk("rst sgn", 32'(DivSign), 0);
    Reset = 1'b0;
    repeat (8) tick();

    f0 = falls;
    issue(1, 8'd13, 8'd2, 1'b0);
    tick();
    chk("t1 grant", 32'(Grant), 32'b0010);
    chk("t1 busy", 32'(Busy), 1);
    wait_done(1, 8'd6, 8'd1, 1'b0, "t1");
    chk("t1 ready toggle", 32'(falls - f0), 1);

    do_reset();
    issue(0, 8'd69, 8'd42, 1'b0);
    issue(2, 8'd255, 8'd5, 1'b0);
    wait_done(0, 8'd1, 8'd27, 1'b0, "t2a");
    wait_done(2, 8'd51, 8'd0, 1'b0, "t2b");

    issue(3, 8'd77, 8'd1, 1'b0);
    wait_done(3, 8'd77, 8'd0, 1'b0, "t3a");
    f0 = falls;
    issue(3, 8'd77, 8'd1, 1'b0);
    tick();
    chk("t3 grant", 32'(Grant), 32'b1000);
    chk("t3 early", 32'(Done), 0);
    tick();
    chk("t3 latency", 32'(Done), 32'b1000);
    wait_done(3, 8'd77, 8'd0, 1'b0, "t3b");
    chk("t3 no toggle", 32'(falls - f0), 0);

    issue(0, 8'd150, 8'd0, 1'b0);
    tick();
    chk("t4 grant", 32'(Grant), 32'b0001);
    tick();
    chk("t4 latency", 32'(Done), 32'b0001);
    wait_done(0, 8'd255, 8'd150, 1'b1, "t4");
    chk("t4 div dvd", 32'(DivDividend), 77);
    chk("t4 div dvs", 32'(DivDivider), 1);

    do_reset();
    for (int i = 0; i < N; i++) issue(i, 8'd150, 8'd150, 1'b0);
    for (int g = 0; g < 5; g++) begin
      wait_done(g % N, 8'd1, 8'd0, 1'b0, "t5");
      Req[g % N] = 1'b1;
    end
    Req = '0;
    tick();

    issue(1, 8'd13, 8'd2, 1'b0);
    n = 0;
    while (DivReady === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("t6 ready low", 32'(n < 50), 1);
    tick();
    Reset = 1'b1;
    Req   = '0;
    tick();
    chk("t6 grant", 32'(Grant), 0);
    chk("t6 done", 32'(Done), 0);
    chk("t6 busy", 32'(Busy), 0);
    chk("t6 q", 32'(Quotient), 0);
    chk("t6 dvd", 32'(DivDividend), 0);
    Reset = 1'b0;
    mptr  = 0;
    tick();
    chk("t6 no done", 32'(Done), 0);
    issue(1, 8'd13, 8'd2, 1'b0);
    wait_done(1, 8'd6, 8'd1, 1'b0, "t6");

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          a = ($urandom_range(3, 0) == 0) ? 8'd77 : 8'($urandom);
          b = bpool[$urandom_range(4, 0)];
          s = 1'($urandom_range(1, 0));
          issue(i, a, b, s);
        end
      end
      while (Req != '0) begin
        own = rr_pick(Req, mptr);
        ex  = ref_div(ReqDividend[own*W +: W],
                      ReqDivider[own*W +: W], ReqSign[own]);
        wait_done(own, ex[2*W-1:W], ex[W-1:0],
                  ReqDivider[own*W +: W] == '0, "rnd");
      end
    end

`ifdef DIV_TIMEOUT_EN
    stuck = 1'b1;
    tick();
    issue(2, 8'd100, 8'd9, 1'b0);
    wait_done(2, 8'd0, 8'd0, 1'b1, "tmo");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_divider_arbiter.md
Name: sign_divider_arbiter

Overview:
Shares one SignDivider instance between NUM_REQ requesters using a round-robin arbiter and a sequencing FSM.
- The block latches the winning requester's operands and drives the divider's operand and Sign inputs.
- It tracks the divider's Ready low-then-high handshake and returns Quotient/Remainder to the winner with a one-cycle Done pulse.
- It bypasses the divider for divide-by-zero and for repeated identical operands; the divider only restarts when its inputs change.

Parameters:
WIDTH, 8, operand/result bit width; matches the divider's INPUT_BIT_WIDTH.
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 64, watchdog limit; used only with DIV_TIMEOUT_EN.

Ports:
Clk  in  1  clock; all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
Req  in  NUM_REQ  per-requester request level; held until Done.
ReqDividend  in  NUM_REQ*WIDTH  flattened dividends; slice i belongs to requester i.
ReqDivider  in  NUM_REQ*WIDTH  flattened divisors.
ReqSign  in  NUM_REQ  per-requester Sign bit.
Grant  out  NUM_REQ  one-hot owner of the divider; 0 when idle.
Done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
Quotient  out  WIDTH  result; valid while Done is high, held until next Done.
Remainder  out  WIDTH  result; valid while Done is high.
Error  out  1  high with Done when the divisor was 0 (or on timeout).
Busy  out  1  high whenever state != IDLE.
DivDividend  out  WIDTH  to divider Dividend.
DivDivider  out  WIDTH  to divider Divider.
DivSign  out  1  to divider Sign.
DivReady  in  1  from divider Ready.
DivQuotient  in  WIDTH  from divider Quotient.
DivRemainder  in  WIDTH  from divider Remainder.

Behaviour:
- Reset (synchronous, wins over everything):
  - All outputs are 0; state is IDLE; round-robin pointer is 0; result cache is invalid.
  - Asserting Reset mid-operation aborts without a Done pulse.
  - Reset drives DivDividend/DivDivider to 0; operands 0/0 are never issued, so the first issue after reset always presents a change to the divider.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE; all outputs are registered.
- IDLE: if Req != 0, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's operands and Sign, set Grant one-hot, go to ISSUE.
  - Later changes to Req or operands are ignored until DONE.
- ISSUE, evaluated in this priority order:
  - Latched divisor == 0: Quotient = all ones, Remainder = latched dividend, Error = 1, go to DONE. No divider activity.
  - Cache valid and {dividend, divisor, sign} equals the last issued triple: reuse the cached Quotient/Remainder, go to DONE.
  - Otherwise, stall while DivReady == 0. Once DivReady == 1, drive the Div* outputs, set the cache tag, and go to WAIT_LOW.
- WAIT_LOW: on DivReady == 0, go to WAIT_HIGH.
- WAIT_HIGH: on DivReady == 1, capture DivQuotient/DivRemainder into the outputs and the cache, mark the cache valid, go to DONE.
- DONE:
  - Done[owner] is high for exactly this cycle.
  - Next edge: Grant and Done go to 0, pointer = owner+1 (wrapping), state returns to IDLE.
  - Error clears on the next grant.
- Latency, with Req sampled high at edge e0:
  - Bypass path: Done is high after e1, Grant drops after e2.
  - Divider path: Done is high one cycle after DivReady is seen high in WAIT_HIGH.
- Back-to-back requests:
  - A minimum of one IDLE cycle separates grants.
  - Simultaneous requests are served strictly round-robin; no requester waits more than NUM_REQ-1 grants.
- Req dropped mid-operation: the operation still completes and the Done pulse is still issued.

Optional Feature:
DIV_TIMEOUT_EN
- Defined: a counter runs in WAIT_LOW/WAIT_HIGH and is cleared on entering WAIT_LOW.
  - When it reaches TIMEOUT_CYCLES, go to DONE with Error = 1, Quotient = 0, Remainder = 0, and invalidate the cache.
- Undefined: no counter; the FSM waits on DivReady indefinitely.

Test Plan:
1. WIDTH=8, NUM_REQ=4; Req[1] with 13/2, Sign 0 -> Grant=0010, DivReady falls then rises, Done=0010 for one cycle, Q=6, R=1, Error=0.
2. Req[0] 69/42 and Req[2] 255/5 asserted in the same cycle -> requester 0 served first (Q=1, R=27), then requester 2 (Q=51, R=0); one IDLE cycle between Done pulses.
3. Requester 3 sends 77/1, then repeats 77/1 -> both Q=77, R=0; second Done arrives 2 cycles after Req is sampled and DivReady never toggles.
4. Req[0] 150/0 -> Error=1, Q=255, R=150 in 2 cycles; Div* outputs unchanged.
5. All four Req held high with 150/150 -> Grant sequence 0001, 0010, 0100, 1000, 0001; each result Q=1, R=0.
6. Reset in WAIT_HIGH -> next cycle all outputs 0, no Done pulse. Then issue 13/2 -> correct Q=6, R=1. With DIV_TIMEOUT_EN, DivReady held at 1 -> Done with Error=1 after TIMEOUT_CYCLES.
